// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: state encoding and Wishbone cycle-type constants shared by the stream reader.
// Contents: state_t (IDLE, WAIT_SPACE, BURST, plus ERROR when WB_STREAM_READER_ERR_EN is defined),
//           CTI_CLASSIC / CTI_INC / CTI_EOB.
package wb_stream_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_BURST
`ifdef WB_STREAM_READER_ERR_EN
    , S_ERROR
`endif
  } state_t;
endpackage

// File: rtl/wb_stream_fifo.sv
// wb_stream_fifo: first-word fall-through FIFO holding words read from the bus until the stream takes them.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_data write side;
//        i_pop read side; o_data head word; o_empty; o_count occupancy (0..2**FIFO_AW).
module wb_stream_fifo #(
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WB_DW-1:0] i_data,
  input  logic             i_pop,
  output logic [WB_DW-1:0] o_data,
  output logic             o_empty,
  output logic [FIFO_AW:0] o_count
);
  logic [WB_DW-1:0] r_mem [2**FIFO_AW];
  logic [FIFO_AW:0] r_wr, r_rd;
  always_ff @(posedge i_clk)
    if (i_push) r_mem[r_wr[FIFO_AW-1:0]] <= i_data;
  // Pointers carry one extra bit so full and empty are distinguishable by subtraction.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + {{FIFO_AW{1'b0}}, i_push};
      r_rd <= r_rd + {{FIFO_AW{1'b0}}, i_pop};
    end
  assign o_data  = r_mem[r_rd[FIFO_AW-1:0]];
  assign o_count = r_wr - r_rd;
  assign o_empty = o_count == '0;
endmodule

// File: rtl/wb_stream_reader_ctrl.sv
// wb_stream_reader_ctrl: Wishbone burst master that reads a ring buffer and streams the words out.
// Ports: wb_clk_i, wb_rst_ni (async active-low); enable_i, start_adr_i, buf_size_i, burst_size_i (config);
//        wb_* Wishbone read master; stream_data_o/stream_valid_o/stream_ready_i output stream;
//        busy_o (not idle); err_o sticky bus error.
// Optional feature: define WB_STREAM_READER_ERR_EN to terminate bursts on wb_err_i and report err_o.
module wb_stream_reader_ctrl
  import wb_stream_pkg::*;
#(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               enable_i,
  input  logic [WB_AW-1:0]   start_adr_i,
  input  logic [WB_AW-1:0]   buf_size_i,
  input  logic [WB_AW-1:0]   burst_size_i,
  output logic [WB_AW-1:0]   wb_adr_o,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic [WB_DW/8-1:0] wb_sel_o,
  output logic               wb_we_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic [2:0]         wb_cti_o,
  output logic [1:0]         wb_bte_o,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  output logic [WB_DW-1:0]   stream_data_o,
  output logic               stream_valid_o,
  input  logic               stream_ready_i,
  output logic               busy_o,
  output logic               err_o
);
  localparam logic [WB_AW-1:0] DEPTH = WB_AW'(2 ** FIFO_AW);
  localparam logic [WB_AW-1:0] BYTES = WB_AW'(WB_DW / 8);
  state_t r_state, w_next;
  logic [WB_AW-1:0] r_start, r_size, r_burst, r_off, r_rem;
  logic [WB_AW-1:0] w_left, w_len, w_free, w_off_inc;
  logic [FIFO_AW:0] w_count;
  logic w_go, w_err, w_ack, w_last, w_pop, w_empty, w_unused;
  assign w_go      = enable_i && buf_size_i != '0 && burst_size_i != '0;
  // A burst stops at the ring end so the address never wraps inside a burst.
  assign w_left    = r_size - r_off;
  assign w_len     = r_burst < w_left ? r_burst : w_left;
  assign w_free    = DEPTH - WB_AW'(w_count);
  assign w_off_inc = r_off + WB_AW'(1);
  assign w_last    = r_rem == WB_AW'(1);
  assign w_unused  = wb_err_i;
`ifdef WB_STREAM_READER_ERR_EN
  logic r_err;
  assign w_err = r_state == S_BURST && wb_err_i;
  assign err_o = r_err;
`else
  assign w_err = 1'b0;
  assign err_o = 1'b0;
`endif
  assign w_ack = r_state == S_BURST && wb_ack_i && !w_err;
  assign w_pop = stream_ready_i && !w_empty;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = w_go ? S_WAIT_SPACE : S_IDLE;
      S_WAIT_SPACE: w_next = !enable_i ? S_IDLE : w_free >= w_len ? S_BURST : S_WAIT_SPACE;
      S_BURST:      w_next = !(w_ack && w_last) ? S_BURST : enable_i ? S_WAIT_SPACE : S_IDLE;
`ifdef WB_STREAM_READER_ERR_EN
      S_ERROR:      w_next = enable_i ? S_ERROR : S_IDLE;
`endif
      default:      w_next = S_IDLE;
    endcase
`ifdef WB_STREAM_READER_ERR_EN
    if (w_err) w_next = S_ERROR;
`endif
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_start <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_off   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_go) begin
        r_start <= start_adr_i;
        r_size  <= buf_size_i;
        r_burst <= burst_size_i > DEPTH ? DEPTH : burst_size_i;
        r_off   <= '0;
      end
      if (r_state == S_WAIT_SPACE && w_next == S_BURST) r_rem <= w_len;
      if (w_ack) begin
        r_off <= w_off_inc == r_size ? '0 : w_off_inc;
        r_rem <= r_rem - WB_AW'(1);
      end
    end
`ifdef WB_STREAM_READER_ERR_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) r_err <= 1'b0;
    else if (w_err) r_err <= 1'b1;
    else if (r_state == S_ERROR && !enable_i) r_err <= 1'b0;
`endif
  wb_stream_fifo #(
    .WB_DW  (WB_DW),
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .i_clk  (wb_clk_i),
    .i_rst_n(wb_rst_ni),
    .i_push (w_ack),
    .i_data (wb_dat_i),
    .i_pop  (w_pop),
    .o_data (stream_data_o),
    .o_empty(w_empty),
    .o_count(w_count)
  );
  assign wb_cyc_o       = r_state == S_BURST;
  assign wb_stb_o       = r_state == S_BURST;
  assign wb_cti_o       = r_state != S_BURST ? CTI_CLASSIC : w_last ? CTI_EOB : CTI_INC;
  assign wb_adr_o       = r_start + r_off * BYTES;
  assign wb_dat_o       = '0;
  assign wb_sel_o       = '1;
  assign wb_we_o        = 1'b0;
  assign wb_bte_o       = 2'b00;
  assign stream_valid_o = !w_empty;
  assign busy_o         = r_state != S_IDLE;
endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// tb_wb_stream_reader_ctrl: self-checking bench for wb_stream_reader_ctrl with a 8-entry FIFO.
module tb_wb_stream_reader_ctrl;
  localparam int AW = 32, DW = 32, FAW = 3, DEPTH = 8;
  logic          wb_clk_i, wb_rst_ni, enable_i;
  logic [AW-1:0] start_adr_i, buf_size_i, burst_size_i, wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i, stream_data_o;
  logic [DW/8-1:0] wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic          stream_valid_o, stream_ready_i, busy_o, err_o;

  wb_stream_reader_ctrl #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .enable_i(enable_i),
    .start_adr_i(start_adr_i), .buf_size_i(buf_size_i), .burst_size_i(burst_size_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .stream_data_o(stream_data_o), .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial begin
    wb_clk_i = 0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  typedef struct {
    logic [31:0] start, bsz, burst, adr;
    logic [2:0]  cti;
  } vec_t;
  vec_t tbl[$];

  int n_chk, n_err, ack_rate, rdy_rate, err_at, n_beat, n_pop, occ;
  logic [31:0] m_start, m_buf, m_burst, m_off, m_rem;
  logic [31:0] q_exp[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] s, b, u, a, input logic [2:0] c);
    vec_t v;
    v.start = s; v.bsz = b; v.burst = u; v.adr = a; v.cti = c;
    tbl.push_back(v);
  endtask

  // One clock: act as Wishbone slave and stream sink, check against the ring-buffer model.
  task automatic cycle();
    logic [31:0] e_adr;
    chk("stream_valid", stream_valid_o, occ != 0);
    wb_ack_i = 0;
    wb_err_i = 0;
    wb_dat_i = '0;
    if (wb_cyc_o && wb_stb_o) begin
      if (err_at != 0 && n_beat + 1 == err_at) begin
        wb_err_i = 1;
        err_at = 0;
      end else if ($urandom_range(99) < ack_rate) begin
        wb_ack_i = 1;
        wb_dat_i = mem_word(wb_adr_o);
        if (m_rem == 0) m_rem = m_burst < m_buf - m_off ? m_burst : m_buf - m_off;
        e_adr = m_start + m_off * 4;
        chk("bus_adr", wb_adr_o, e_adr);
        chk("bus_cti", {29'd0, wb_cti_o}, m_rem == 1 ? 32'd7 : 32'd2);
        q_exp.push_back(mem_word(e_adr));
        m_off = (m_off + 1) % m_buf;
        m_rem--;
        n_beat++;
        occ++;
      end
    end
    stream_ready_i = $urandom_range(99) < rdy_rate;
    if (stream_valid_o && stream_ready_i) begin
      if (q_exp.size() == 0) chk("stream_extra", stream_data_o, 32'hDEAD_BEEF);
      else chk("stream_data", stream_data_o, q_exp.pop_front());
      occ--;
      n_pop++;
    end
    chk("fifo_bound", occ <= DEPTH, 1);
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_ni = 0; enable_i = 0; wb_ack_i = 0; wb_err_i = 0; stream_ready_i = 0;
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1;
    q_exp.delete();
    occ = 0; n_beat = 0; n_pop = 0; err_at = 0; ack_rate = 100; rdy_rate = 100;
  endtask

  task automatic start_run(input logic [31:0] s, b, u);
    start_adr_i = s; buf_size_i = b; burst_size_i = u; enable_i = 1;
    m_start = s; m_buf = b; m_burst = u > DEPTH ? DEPTH : u; m_off = 0; m_rem = 0;
  endtask

  task automatic wait_for_cyc(input int lim);
    for (int i = 0; i < lim && !wb_cyc_o; i++) cycle();
    chk("cyc_timeout", wb_cyc_o, 1);
  endtask

  task automatic wait_beats(input int n, input int lim);
    for (int i = 0; i < lim && n_beat < n; i++) cycle();
    chk("beat_timeout", n_beat >= n, 1);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy_o; i++) cycle();
    chk("idle_timeout", busy_o, 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    wb_rst_ni = 1; enable_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0; stream_ready_i = 0;
    start_adr_i = '0; buf_size_i = '0; burst_size_i = '0;
    q_exp.delete(); occ = 0; n_beat = 0; n_pop = 0; err_at = 0; ack_rate = 100; rdy_rate = 100;
    #1 wb_rst_ni = 0;
    @(posedge wb_clk_i);
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cti", {29'd0, wb_cti_o}, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_valid", stream_valid_o, 0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'hF);
    wb_rst_ni = 1;

    // Directed bus sequences: ring wrap, partial burst at ring end, clamp, single-beat bursts.
    add(32'h1000, 8, 4, 32'h1000, 3'b010); add(32'h1000, 8, 4, 32'h1004, 3'b010);
    add(32'h1000, 8, 4, 32'h1008, 3'b010); add(32'h1000, 8, 4, 32'h100C, 3'b111);
    add(32'h1000, 8, 4, 32'h1010, 3'b010); add(32'h1000, 8, 4, 32'h1014, 3'b010);
    add(32'h1000, 8, 4, 32'h1018, 3'b010); add(32'h1000, 8, 4, 32'h101C, 3'b111);
    add(32'h1000, 8, 4, 32'h1000, 3'b010);
    add(32'h1000, 6, 4, 32'h1000, 3'b010); add(32'h1000, 6, 4, 32'h1004, 3'b010);
    add(32'h1000, 6, 4, 32'h1008, 3'b010); add(32'h1000, 6, 4, 32'h100C, 3'b111);
    add(32'h1000, 6, 4, 32'h1010, 3'b010); add(32'h1000, 6, 4, 32'h1014, 3'b111);
    add(32'h1000, 6, 4, 32'h1000, 3'b010); add(32'h1000, 6, 4, 32'h1004, 3'b010);
    add(32'h1000, 6, 4, 32'h1008, 3'b010); add(32'h1000, 6, 4, 32'h100C, 3'b111);
    add(32'h2000, 20, 100, 32'h2000, 3'b010); add(32'h2000, 20, 100, 32'h2004, 3'b010);
    add(32'h2000, 20, 100, 32'h2008, 3'b010); add(32'h2000, 20, 100, 32'h200C, 3'b010);
    add(32'h2000, 20, 100, 32'h2010, 3'b010); add(32'h2000, 20, 100, 32'h2014, 3'b010);
    add(32'h2000, 20, 100, 32'h2018, 3'b010); add(32'h2000, 20, 100, 32'h201C, 3'b111);
    add(32'h2000, 20, 100, 32'h2020, 3'b010);
    add(32'h3000, 3, 2, 32'h3000, 3'b010); add(32'h3000, 3, 2, 32'h3004, 3'b111);
    add(32'h3000, 3, 2, 32'h3008, 3'b111); add(32'h3000, 3, 2, 32'h3000, 3'b010);
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].start != tbl[i-1].start || tbl[i].bsz != tbl[i-1].bsz ||
          tbl[i].burst != tbl[i-1].burst) begin
        do_reset();
        start_run(tbl[i].start, tbl[i].bsz, tbl[i].burst);
      end
      wait_for_cyc(20);
      chk("tbl_adr", wb_adr_o, tbl[i].adr);
      chk("tbl_cti", {29'd0, wb_cti_o}, {29'd0, tbl[i].cti});
      cycle();
    end

    // Zero sizes never leave idle.
    do_reset();
    start_run(32'h1000, 0, 4);
    repeat (3) cycle();
    chk("zero_buf_idle", busy_o, 0);
    start_run(32'h1000, 4, 0);
    repeat (3) cycle();
    chk("zero_burst_idle", busy_o, 0);

    // Backpressure: two bursts fill the FIFO, the third waits until 4 entries are free.
    do_reset();
    rdy_rate = 0;
    start_run(32'h1000, 8, 4);
    wait_beats(8, 60);
    repeat (5) cycle();
    chk("bp_wait_cyc", wb_cyc_o, 0);
    chk("bp_wait_busy", busy_o, 1);
    rdy_rate = 100; cycle(); rdy_rate = 0;
    repeat (5) cycle();
    chk("bp_one_pop_cyc", wb_cyc_o, 0);
    rdy_rate = 100; cycle(); cycle(); rdy_rate = 0;
    repeat (5) cycle();
    chk("bp_three_pop_cyc", wb_cyc_o, 0);
    chk("bp_three_pop_beats", n_beat, 8);
    rdy_rate = 100; cycle(); rdy_rate = 0;
    wait_for_cyc(5);
    chk("bp_resume_adr", wb_adr_o, 32'h1000);

    // enable_i dropped on beat 2 of 4: burst completes, then idle.
    do_reset();
    start_run(32'h1000, 8, 4);
    wait_for_cyc(10);
    cycle();
    enable_i = 0;
    cycle(); cycle(); cycle();
    chk("drop_beats", n_beat, 4);
    chk("drop_cyc", wb_cyc_o, 0);
    chk("drop_busy", busy_o, 0);
    repeat (3) cycle();
    chk("drop_no_more", n_beat, 4);

    // Bus error on beat 3.
    do_reset();
    rdy_rate = 0;
    err_at = 3;
    start_run(32'h1000, 8, 4);
    wait_beats(2, 20);
    cycle();
`ifdef WB_STREAM_READER_ERR_EN
    chk("err_cyc", wb_cyc_o, 0);
    chk("err_flag", err_o, 1);
    chk("err_busy", busy_o, 1);
    enable_i = 0;
    cycle();
    chk("err_idle", busy_o, 0);
    chk("err_clear", err_o, 0);
    rdy_rate = 100;
    repeat (6) cycle();
    chk("err_words", n_pop, 2);
`else
    chk("err_ignored_cyc", wb_cyc_o, 1);
    chk("err_tied", err_o, 0);
    wait_beats(4, 20);
    enable_i = 0;
    wait_idle(40);
    chk("err_tied_end", err_o, 0);
`endif

    // Reset pulsed mid-burst.
    do_reset();
    rdy_rate = 0;
    start_run(32'h1000, 8, 4);
    wait_beats(1, 20);
    chk("rstmid_pre_cyc", wb_cyc_o, 1);
    chk("rstmid_pre_valid", stream_valid_o, 1);
    wb_ack_i = 0;
    wb_rst_ni = 0;
    #1;
    chk("rstmid_cyc", wb_cyc_o, 0);
    chk("rstmid_stb", wb_stb_o, 0);
    chk("rstmid_valid", stream_valid_o, 0);
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1;
    enable_i = 0;
    q_exp.delete(); occ = 0; n_beat = 0;
    cycle(); cycle();
    chk("rstmid_busy", busy_o, 0);

    // Random configs, ack and ready rates; config inputs scrambled while running.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      ack_rate = $urandom_range(100, 30);
      rdy_rate = $urandom_range(100, 10);
      start_run(32'h4000 + ($urandom_range(255) << 2), $urandom_range(12, 1), $urandom_range(12, 1));
      cycle(); cycle();
      start_adr_i = $urandom; buf_size_i = $urandom_range(40, 1); burst_size_i = $urandom_range(40, 1);
      repeat (300) cycle();
      enable_i = 0;
      wait_idle(200);
      rdy_rate = 100;
      for (int i = 0; i < 20 && stream_valid_o; i++) cycle();
      chk("rand_drain_q", q_exp.size(), 0);
      chk("rand_drain_valid", stream_valid_o, 0);
      chk("rand_progress", n_beat > 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
